alu_rr_arbiter: RTL and testbench

//  Shares the single combinational 32-bit ALU between two requesters (e.g. main datapath, CSR/debug unit).

---
 rtl/alu_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 19 +
 rtl/alu_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_rr_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM encoding and op legality check.
package alu_pkg;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpLui  = 4'b0001;
  localparam logic [3:0] OpOri  = 4'b0010;
  localparam logic [3:0] OpSlli = 4'b0011;
  localparam logic [3:0] OpSrli = 4'b0100;
  localparam logic [3:0] OpSub  = 4'b0101;
  localparam logic [3:0] OpAnd  = 4'b0111;
  localparam logic [3:0] OpXor  = 4'b1000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {OpAdd, OpLui, OpOri, OpSlli, OpSrli, OpSub, OpAnd, OpXor};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright; on a tie the one not served last wins.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic grant_valid_o
);

  always_comb begin
    grant_valid_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = valid1_i;
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters, one op in flight at a time.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [OP_WIDTH-1:0]   req0_op_i,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  output logic                  resp0_valid_o,
  input  logic                  resp0_ready_i,
  output logic [DATA_WIDTH-1:0] resp0_result_o,
  output logic                  resp0_zero_o,
  output logic                  resp0_err_o,

  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [OP_WIDTH-1:0]   req1_op_i,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  output logic                  resp1_valid_o,
  input  logic                  resp1_ready_i,
  output logic [DATA_WIDTH-1:0] resp1_result_o,
  output logic                  resp1_zero_o,
  output logic                  resp1_err_o,

  output logic [OP_WIDTH-1:0]   alu_op_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_zero_i
);

  state_e                state_q;
  logic                  last_grant_q;
  logic                  grant_q;
  logic [OP_WIDTH-1:0]   alu_op_q;
  logic [DATA_WIDTH-1:0] alu_a_q;
  logic [DATA_WIDTH-1:0] alu_b_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic                  err_q;
  logic                  resp0_valid_q;
  logic                  resp1_valid_q;

  logic grant;
  logic grant_valid;
  logic idle;
  logic resp_done;

  rr_arb2 u_rr_arb2 (
    .valid0_i      (req0_valid_i),
    .valid1_i      (req1_valid_i),
    .last_grant_i  (last_grant_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  // Gated by reset so no ready is offered while the block is held in reset.
  assign idle         = reset & (state_q == StIdle);
  assign req0_ready_o = idle & grant_valid & ~grant;
  assign req1_ready_o = idle & grant_valid & grant;
  assign resp_done    = (resp0_valid_q & resp0_ready_i) | (resp1_valid_q & resp1_ready_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      result_q      <= '0;
      zero_q        <= 1'b0;
      err_q         <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            grant_q  <= grant;
            alu_op_q <= grant ? req1_op_i : req0_op_i;
            alu_a_q  <= grant ? req1_a_i : req0_a_i;
            alu_b_q  <= grant ? req1_b_i : req0_b_i;
            state_q  <= StExec;
          end
        end
        StExec: begin
          // Illegal ops still go to the ALU; only the error flag marks them.
          result_q      <= alu_result_i;
          zero_q        <= alu_zero_i;
          err_q         <= ~is_legal_op(alu_op_q);
          resp0_valid_q <= ~grant_q;
          resp1_valid_q <= grant_q;
          state_q       <= StResp;
        end
        StResp: begin
          if (resp_done) begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            last_grant_q  <= grant_q;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_op_o       = alu_op_q;
  assign alu_a_o        = alu_a_q;
  assign alu_b_o        = alu_b_q;

  assign resp0_valid_o  = resp0_valid_q;
  assign resp0_result_o = result_q;
  assign resp0_zero_o   = zero_q;
  assign resp0_err_o    = err_q;

  assign resp1_valid_o  = resp1_valid_q;
  assign resp1_result_o = result_q;
  assign resp1_zero_o   = zero_q;
  assign resp1_err_o    = err_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: behavioural ALU, vector table, scoreboard and multi-cycle sequences.
module tb_alu_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero, resp0_err;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero, resp1_err;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;

  alu_rr_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req0_valid_i   (req0_valid),
    .req0_ready_o   (req0_ready),
    .req0_op_i      (req0_op),
    .req0_a_i       (req0_a),
    .req0_b_i       (req0_b),
    .resp0_valid_o  (resp0_valid),
    .resp0_ready_i  (resp0_ready),
    .resp0_result_o (resp0_result),
    .resp0_zero_o   (resp0_zero),
    .resp0_err_o    (resp0_err),
    .req1_valid_i   (req1_valid),
    .req1_ready_o   (req1_ready),
    .req1_op_i      (req1_op),
    .req1_a_i       (req1_a),
    .req1_b_i       (req1_b),
    .resp1_valid_o  (resp1_valid),
    .resp1_ready_i  (resp1_ready),
    .resp1_result_o (resp1_result),
    .resp1_zero_o   (resp1_zero),
    .resp1_err_o    (resp1_err),
    .alu_op_o       (alu_op),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .alu_result_i   (alu_result),
    .alu_zero_i     (alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; LUI is modelled as B << 12, undefined codes return 0.
  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_b << 12;
      4'b0010: alu_result = alu_a | alu_b;
      4'b0011: alu_result = alu_a << alu_b[4:0];
      4'b0100: alu_result = alu_a >> alu_b[4:0];
      4'b0101: alu_result = alu_a - alu_b;
      4'b0111: alu_result = alu_a & alu_b;
      4'b1000: alu_result = alu_a ^ alu_b;
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        req;
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          acc;
  } sb_t;

  sb_t         sbq[$];
  logic        grant_log[$];
  sb_t         mon_e;
  bit          lat_done = 1'b0;
  logic [31:0] exp_res[2];
  logic        exp_zero[2];
  logic        exp_err[2];

  // Scoreboard: push on request handshake, compare every response cycle, pop on response handshake.
  always @(negedge clk) begin
    if (!reset) begin
      sbq.delete();
      lat_done = 1'b0;
    end else begin
      if (req0_valid && req0_ready) begin
        sbq.push_back('{1'b0, exp_res[0], exp_zero[0], exp_err[0], cyc});
        grant_log.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        sbq.push_back('{1'b1, exp_res[1], exp_zero[1], exp_err[1], cyc});
        grant_log.push_back(1'b1);
      end
      if (resp0_valid || resp1_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", {30'b0, resp1_valid, resp0_valid}, 32'd0);
        end else begin
          mon_e = sbq[0];
          chk("resp_port", {30'b0, resp1_valid, resp0_valid}, mon_e.req ? 32'd2 : 32'd1);
          if (!lat_done) begin
            chk("latency", cyc - mon_e.acc, 32'd2);
            lat_done = 1'b1;
          end
          if (!mon_e.req) begin
            chk("resp0_result", resp0_result, mon_e.res);
            chk("resp0_zero", resp0_zero, mon_e.zero);
            chk("resp0_err", resp0_err, mon_e.err);
          end else begin
            chk("resp1_result", resp1_result, mon_e.res);
            chk("resp1_zero", resp1_zero, mon_e.zero);
            chk("resp1_err", resp1_err, mon_e.err);
          end
          if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
            void'(sbq.pop_front());
            lat_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic set_req(input logic req, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic zero,
                         input logic err);
    exp_res[req]  = res;
    exp_zero[req] = zero;
    exp_err[req]  = err;
    if (!req) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
  endtask

  // Waits for the handshake on one port, then drops valid just after the accepting edge.
  task automatic wait_accept(input logic req, input string name, input bit expect_now);
    bit got = 1'b0;
    bit rdy;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      rdy = req ? req1_ready : req0_ready;
      if (i == 0 && expect_now) chk({name, "_ready_same_cycle"}, rdy, 1);
      if (rdy) got = 1'b1;
    end
    if (!got) chk({name, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    if (!req) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !resp0_valid && !resp1_valid) done = 1'b1;
    end
    if (!done) chk({name, "_idle_timeout"}, sbq.size(), 0);
  endtask

  task automatic load_slli(input logic req, input int i);
    int k = 3 * i + 1;
    set_req(req, 4'b0011, 32'd1, k, 32'd1 << k, 1'b0, 1'b0);
  endtask

  task automatic serve_both(input int per_req, input bit slli_mode);
    int done0 = 0;
    int done1 = 0;
    bit h0, h1;
    for (int c = 0; c < 300 && (req0_valid || req1_valid); c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (h0) begin
        done0++;
        if (slli_mode && done0 < per_req) load_slli(1'b0, 2 * done0);
        else req0_valid = 1'b0;
      end
      if (h1) begin
        done1++;
        if (slli_mode && done1 < per_req) load_slli(1'b1, 2 * done1 + 1);
        else req1_valid = 1'b0;
      end
    end
    chk("serve_both_drained", {30'b0, req1_valid, req0_valid}, 32'd0);
    wait_idle("serve_both");
  endtask

  typedef struct {
    logic        req;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'b0110, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 4'b1000, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'b0101, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 4'b0111, 32'hF0, 32'h0F, 32'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 4'b0100, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 4'b1111, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 4'b0001, 32'd0, 32'h12345, 32'h12345000, 1'b0, 1'b0};

    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 4'b0; req0_a = 32'h0; req0_b = 32'h0;
    req1_op = 4'b0; req1_a = 32'h0; req1_b = 32'h0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;

    // Reset state, with a requester already waiting.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_valid0", resp0_valid, 0);
    chk("rst_valid1", resp1_valid, 0);
    chk("rst_err0", resp0_err, 0);
    chk("rst_err1", resp1_err, 0);
    chk("rst_result0", resp0_result, 0);
    chk("rst_result1", resp1_result, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Single-requester vectors.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      set_req(vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero,
              vecs[i].err);
      wait_accept(vecs[i].req, $sformatf("vec%0d", i), 1'b1);
      wait_idle($sformatf("vec%0d", i));
    end

    // Both valid after req1 was served last: req0 must go first.
    grant_log.delete();
    @(posedge clk); #1;
    set_req(1'b0, 4'b0101, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
    set_req(1'b1, 4'b0010, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
    serve_both(1, 1'b0);
    chk("both_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("both_first", grant_log[0], 0);
      chk("both_second", grant_log[1], 1);
    end

    // Response stall: req1 must wait while resp0 is held.
    resp0_ready = 1'b0;
    @(posedge clk); #1;
    set_req(1'b0, 4'b0000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    wait_accept(1'b0, "stall_req0", 1'b1);
    set_req(1'b1, 4'b1000, 32'hA5, 32'h5A, 32'hFF, 1'b0, 1'b0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (resp0_valid) seen = 1'b1;
      end
      chk("stall_resp0_seen", seen, 1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready1_low", req1_ready, 0);
      chk("stall_resp0_held", resp0_valid, 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp0_ready = 1'b1;
    serve_both(1, 1'b0);

    // Reset during EXEC drops the transaction.
    @(posedge clk); #1;
    set_req(1'b0, 4'b0000, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
    wait_accept(1'b0, "rst_exec", 1'b1);
    chk("exec_alu_a", alu_a, 32'd10);
    chk("exec_alu_b", alu_b, 32'd20);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_exec_ready0", req0_ready, 0);
    chk("rst_exec_valid0", resp0_valid, 0);
    chk("rst_exec_alu_a", alu_a, 0);
    chk("rst_exec_alu_b", alu_b, 0);
    chk("rst_exec_alu_op", alu_op, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_exec_no_resp0", resp0_valid, 0);
    end
    @(posedge clk); #1;
    set_req(1'b1, 4'b0000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0);
    wait_accept(1'b1, "post_rst", 1'b1);
    wait_idle("post_rst");

    // Eight back-to-back SLLI ops with both requesters always valid.
    grant_log.delete();
    @(posedge clk); #1;
    load_slli(1'b0, 0);
    load_slli(1'b1, 1);
    serve_both(4, 1'b1);
    chk("rr_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++) begin
      chk($sformatf("rr_grant%0d", i), grant_log[i], i % 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
